rd_rob: RTL and testbench
=========================

RD_ROB -- requirements
Module: rd_rob

Interface
REQ-001 Parameter TID_WIDTH, default `TID_WIDTH, transaction-tag width; DEPTH = 2**TID_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default `AXI_DATA_WIDTH, read-data width.
REQ-003 Parameter ID_WIDTH, default `AXI_ID_WIDTH, CPU-side AXI ID width.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 alloc_valid_i  in  1  request-side asks for a TID; alloc_id_i  in  ID_WIDTH  CPU AXI ID to store.
REQ-007 alloc_ready_o  out  1  entry free; alloc_tid_o  out  TID_WIDTH  TID granted on valid&ready.
REQ-008 rob_wren_i  in  1, rob_data_i  in  TID_WIDTH+DATA_WIDTH {tid,data}  read-hit write from tag comparator.
REQ-009 rob_afull_o  out  1  hit-port throttle to tag comparator.
REQ-010 refill_valid_i  in  1, refill_tid_i  in  TID_WIDTH, refill_data_i  in  DATA_WIDTH  read-miss data from memory controller; refill_ready_o  out  1.
REQ-011 rid_o  out  ID_WIDTH, rdata_o  out  DATA_WIDTH, rresp_o  out  2, rlast_o  out  1, rvalid_o  out  1, rready_i  in  1  CPU AXI R channel.
REQ-012 err_o  out  1  sticky protocol-error flag.

Function
REQ-013 Circular buffer: head (oldest allocated), tail (next free), count of TID_WIDTH+1 bits; pointers wrap DEPTH-1 -> 0.
REQ-014 Alloc: alloc_tid_o = tail; alloc_ready_o = (count < DEPTH), from registered count only; on valid&ready store alloc_id_i at tail, clear entry filled bit, tail+1, count+1.
REQ-015 Full (count == DEPTH): alloc_ready_o = 0 even in a cycle where head retires.
REQ-016 Hit write: rob_wren_i stores data at tid, sets filled; accepted unconditionally.
REQ-017 Refill write: refill_ready_o = 1 always; valid&ready stores data at refill_tid_i, sets filled.
REQ-018 Hit and refill in same cycle to different TIDs: both written; same TID: refill wins, err_o set.
REQ-019 Write to unallocated entry or already-filled entry: data dropped, err_o set; err_o clears only on reset.
REQ-020 rob_afull_o = 1 when filled-but-unretired entry count >= DEPTH-1, registered.
REQ-021 Output stage: one register slot; loads when slot empty or (rvalid_o & rready_i), and head entry filled and count != 0.
REQ-022 Load: rid_o = stored ID, rdata_o = entry data, rresp_o = 2'b00, rlast_o = 1; clear filled, head+1, count-1 in the same cycle.
REQ-023 Latency (no bypass): head written cycle N, slot free -> rvalid_o high cycle N+2.
REQ-024 rvalid_o held, payload stable until rready_i; back-to-back filled entries stream at one beat per cycle.
REQ-025 Retirement strictly in allocation order; a filled non-head entry waits for all older entries.
REQ-026 Alloc and retire same cycle: count unchanged, both pointers advance.

Reset
REQ-027 rst: head, tail, count = 0; all filled bits = 0; err_o = 0; rvalid_o = 0; rob_afull_o = 0; rid_o, rdata_o, rresp_o, rlast_o = 0.
REQ-028 rst mid-operation discards all allocations and pending data; alloc_ready_o = 1 the cycle after rst deasserts.
REQ-029 Storage array data not reset.

Configuration
REQ-030 Macro RD_ROB_BYPASS_EN: when defined, a write (hit or refill) to head while the output slot is empty or draining loads the slot directly; rvalid_o high cycle N+1.
REQ-031 Without RD_ROB_BYPASS_EN: no bypass path; REQ-023 latency applies to all writes.

Structure
REQ-032 Shared package (TYPEDEF.svh): TID_WIDTH, AXI widths, RRESP_OKAY constant, rob entry typedef {id, data}.
REQ-033 One sub-module rd_rob_storage: DEPTH-entry array, two write ports (hit, refill), one read port at head, filled-bit vector.

Verification
REQ-034 Alloc 4 (IDs 3,5,7,9), hits to TIDs 3,2,1,0 in reverse -> R beats with rid 3,5,7,9 in order, rlast_o = 1 each.
REQ-035 Alloc DEPTH entries -> alloc_ready_o = 0; retire one -> alloc_ready_o = 1 next cycle, alloc_tid_o = 0 (wrap).
REQ-036 Hit to TID 1 and refill to TID 2 same cycle, both allocated -> both delivered, err_o = 0; same TID both ports -> refill data delivered, err_o = 1.
REQ-037 rready_i low 5 cycles with 3 filled entries -> rid_o/rdata_o stable, no loss, then 3 consecutive beats.
REQ-038 Head write at cycle 10, slot empty -> rvalid_o at 12 (no macro) / 11 (RD_ROB_BYPASS_EN).
REQ-039 rst asserted with 3 allocated, 2 filled -> next cycle rvalid_o = 0, count 0, first new alloc_tid_o = 0.

Source files
------------

// File: rtl/rd_rob_pkg.sv
// Shared widths, response codes and entry type for the read reorder buffer.
// Optional feature macro used by rd_rob: RD_ROB_BYPASS_EN.
`ifndef TID_WIDTH
`define TID_WIDTH 3
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package rd_rob_pkg;
    localparam int TID_W      = `TID_WIDTH;
    localparam int AXI_DATA_W = `AXI_DATA_WIDTH;
    localparam int AXI_ID_W   = `AXI_ID_WIDTH;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/rd_rob_storage.sv
// Entry storage for rd_rob: ID/data arrays, hit and refill write ports,
// one read port at the head, and the per-entry filled bits.
module rd_rob_storage #(
    parameter int TID_WIDTH  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_en,
    input  logic [TID_WIDTH-1:0]      alloc_idx,
    input  logic [ID_WIDTH-1:0]       alloc_id,
    input  logic                      hit_en,
    input  logic [TID_WIDTH-1:0]      hit_idx,
    input  logic [DATA_WIDTH-1:0]     hit_data,
    input  logic                      refill_en,
    input  logic [TID_WIDTH-1:0]      refill_idx,
    input  logic [DATA_WIDTH-1:0]     refill_data,
    input  logic                      clr_en,
    input  logic [TID_WIDTH-1:0]      rd_idx,
    output logic [ID_WIDTH-1:0]       rd_id,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [2**TID_WIDTH-1:0]   filled
);
    localparam int DEPTH = 2**TID_WIDTH;

    logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (alloc_en)  id_mem[alloc_idx]    <= alloc_id;
        if (hit_en)    data_mem[hit_idx]    <= hit_data;
        if (refill_en) data_mem[refill_idx] <= refill_data;
    end

    // Clear and set never target the same entry: the top only enables
    // writes to allocated, unfilled entries that are not being retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            filled <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((clr_en && rd_idx == TID_WIDTH'(i)) ||
                    (alloc_en && alloc_idx == TID_WIDTH'(i)))
                    filled[i] <= 1'b0;
                else if ((hit_en && hit_idx == TID_WIDTH'(i)) ||
                         (refill_en && refill_idx == TID_WIDTH'(i)))
                    filled[i] <= 1'b1;
            end
        end
    end

    assign rd_id   = id_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];
endmodule

// File: rtl/rd_rob.sv
// Read reorder buffer: hands out TIDs in order, accepts out-of-order hit and
// refill data, and returns AXI R beats in allocation order.
// Optional head-write bypass into the output slot: RD_ROB_BYPASS_EN.
module rd_rob
    import rd_rob_pkg::*;
#(
    parameter int TID_WIDTH  = TID_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int ID_WIDTH   = AXI_ID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_valid_i,
    input  logic [ID_WIDTH-1:0]           alloc_id_i,
    output logic                          alloc_ready_o,
    output logic [TID_WIDTH-1:0]          alloc_tid_o,
    input  logic                          rob_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_i,
    output logic                          rob_afull_o,
    input  logic                          refill_valid_i,
    input  logic [TID_WIDTH-1:0]          refill_tid_i,
    input  logic [DATA_WIDTH-1:0]         refill_data_i,
    output logic                          refill_ready_o,
    output logic [ID_WIDTH-1:0]           rid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rlast_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic                          err_o
);
    localparam int DEPTH = 2**TID_WIDTH;

    logic [TID_WIDTH-1:0]  head, tail;
    logic [TID_WIDTH:0]    count;
    logic [DEPTH-1:0]      filled, allocated;
    logic [TID_WIDTH-1:0]  hit_tid;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [TID_WIDTH:0]    pending;
    logic                  alloc_fire, same_tid, hit_ok, refill_ok, err_set;
    logic                  slot_free, load_norm, bypass, retire, hit_en, refill_en;
    logic [DATA_WIDTH-1:0] byp_data;

    assign {hit_tid, hit_data} = rob_data_i;

    assign alloc_ready_o  = (count < (TID_WIDTH+1)'(DEPTH));
    assign alloc_tid_o    = tail;
    assign refill_ready_o = 1'b1;
    assign alloc_fire     = alloc_valid_i & alloc_ready_o;

    // An entry is live when its distance from head is below count.
    always_comb begin
        allocated = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [TID_WIDTH-1:0] offset;
            offset       = TID_WIDTH'(i) - head;
            allocated[i] = ({1'b0, offset} < count);
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            pending = pending + (TID_WIDTH+1)'(filled[i]);
    end

    assign same_tid  = rob_wren_i & refill_valid_i & (hit_tid == refill_tid_i);
    assign hit_ok    = rob_wren_i & allocated[hit_tid] & ~filled[hit_tid] & ~same_tid;
    assign refill_ok = refill_valid_i & allocated[refill_tid_i] & ~filled[refill_tid_i];
    assign err_set   = (rob_wren_i & (~allocated[hit_tid] | filled[hit_tid]))
                     | (refill_valid_i & (~allocated[refill_tid_i] | filled[refill_tid_i]))
                     | same_tid;

    assign slot_free = ~rvalid_o | rready_i;
    assign load_norm = slot_free & filled[head] & (count != '0);

`ifdef RD_ROB_BYPASS_EN
    logic byp_hit, byp_refill;
    assign byp_hit    = hit_ok & (hit_tid == head);
    assign byp_refill = refill_ok & (refill_tid_i == head);
    assign bypass     = slot_free & ~filled[head] & (byp_hit | byp_refill);
    assign byp_data   = byp_refill ? refill_data_i : hit_data;
`else
    assign bypass   = 1'b0;
    assign byp_data = '0;
`endif

    assign retire    = load_norm | bypass;
    assign hit_en    = hit_ok & ~(bypass & (hit_tid == head));
    assign refill_en = refill_ok & ~(bypass & (refill_tid_i == head));

    rd_rob_storage #(
        .TID_WIDTH  (TID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_storage (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (alloc_fire),
        .alloc_idx   (tail),
        .alloc_id    (alloc_id_i),
        .hit_en      (hit_en),
        .hit_idx     (hit_tid),
        .hit_data    (hit_data),
        .refill_en   (refill_en),
        .refill_idx  (refill_tid_i),
        .refill_data (refill_data_i),
        .clr_en      (retire),
        .rd_idx      (head),
        .rd_id       (rd_id),
        .rd_data     (rd_data),
        .filled      (filled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            err_o       <= 1'b0;
            rob_afull_o <= 1'b0;
            rvalid_o    <= 1'b0;
            rid_o       <= '0;
            rdata_o     <= '0;
            rresp_o     <= '0;
            rlast_o     <= 1'b0;
        end else begin
            if (alloc_fire) tail <= tail + 1'b1;
            if (retire)     head <= head + 1'b1;
            count <= count + {{TID_WIDTH{1'b0}}, alloc_fire} - {{TID_WIDTH{1'b0}}, retire};
            if (err_set) err_o <= 1'b1;
            rob_afull_o <= (pending >= (TID_WIDTH+1)'(DEPTH-1));
            if (retire) begin
                rvalid_o <= 1'b1;
                rid_o    <= rd_id;
                rdata_o  <= bypass ? byp_data : rd_data;
                rresp_o  <= RRESP_OKAY;
                rlast_o  <= 1'b1;
            end else if (rready_i) begin
                rvalid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rd_rob.sv
// Self-checking bench for rd_rob: directed scenarios plus randomized traffic
// checked against an in-order queue model of outstanding transactions.
module tb_rd_rob;
    import rd_rob_pkg::*;

    localparam int TW    = TID_W;
    localparam int DW    = AXI_DATA_W;
    localparam int IW    = AXI_ID_W;
    localparam int DEPTH = 2**TW;
`ifdef RD_ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid_i, alloc_ready_o, rob_wren_i, rob_afull_o;
    logic [IW-1:0] alloc_id_i, rid_o;
    logic [TW-1:0] alloc_tid_o, refill_tid_i;
    logic [TW+DW-1:0] rob_data_i;
    logic          refill_valid_i, refill_ready_o, rlast_o, rvalid_o, rready_i, err_o;
    logic [DW-1:0] refill_data_i, rdata_o;
    logic [1:0]    rresp_o;

    rd_rob #(.TID_WIDTH(TW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid_i), .alloc_id_i(alloc_id_i),
        .alloc_ready_o(alloc_ready_o), .alloc_tid_o(alloc_tid_o),
        .rob_wren_i(rob_wren_i), .rob_data_i(rob_data_i), .rob_afull_o(rob_afull_o),
        .refill_valid_i(refill_valid_i), .refill_tid_i(refill_tid_i),
        .refill_data_i(refill_data_i), .refill_ready_o(refill_ready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tid;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        bit            filled;
    } ent_t;

    ent_t          q[$];
    rob_entry_t    beats[$];
    bit            exp_err;
    logic [TW-1:0] next_tid;
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mwrite(input logic [TW-1:0] tid, input logic [DW-1:0] d);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tid == tid && !q[i].filled) begin
                q[i].filled = 1'b1;
                q[i].data   = d;
                return;
            end
        end
        exp_err = 1'b1;
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step(input bit a_v, input logic [IW-1:0] a_id,
                        input bit h_v, input logic [TW-1:0] h_tid, input logic [DW-1:0] h_d,
                        input bit f_v, input logic [TW-1:0] f_tid, input logic [DW-1:0] f_d,
                        input bit rr);
        ent_t e;
        bit   a_fire;
        alloc_valid_i  = a_v;  alloc_id_i    = a_id;
        rob_wren_i     = h_v;  rob_data_i    = {h_tid, h_d};
        refill_valid_i = f_v;  refill_tid_i  = f_tid; refill_data_i = f_d;
        rready_i       = rr;
        chk("alloc_ready", alloc_ready_o, 64'((q.size() - int'(rvalid_o)) < DEPTH));
        chk("refill_ready", refill_ready_o, 1);
        if (rvalid_o && rr) begin
            if (q.size() == 0) begin
                chk("beat_unexpected", rvalid_o, 0);
            end else begin
                e = q.pop_front();
                chk("beat_filled", 64'(e.filled), 1);
                chk("rid", rid_o, e.id);
                chk("rdata", rdata_o, e.data);
                chk("rlast", rlast_o, 1);
                chk("rresp", rresp_o, RRESP_OKAY);
                beats.push_back(rob_entry_t'({rid_o, rdata_o}));
            end
        end
        a_fire = a_v && alloc_ready_o;
        if (a_fire) chk("alloc_tid", alloc_tid_o, next_tid);
        if (h_v && f_v && h_tid == f_tid) begin
            exp_err = 1'b1;
            mwrite(f_tid, f_d);
        end else begin
            if (h_v) mwrite(h_tid, h_d);
            if (f_v) mwrite(f_tid, f_d);
        end
        if (a_fire) begin
            e.tid = next_tid; e.id = a_id; e.data = '0; e.filled = 1'b0;
            q.push_back(e);
            next_tid = next_tid + 1'b1;
        end
        @(negedge clk);
        chk("err", err_o, exp_err);
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) step(0, '0, 0, '0, '0, 0, '0, '0, rr);
    endtask

    task automatic alloc(input logic [IW-1:0] id, input bit rr);
        step(1, id, 0, '0, '0, 0, '0, '0, rr);
    endtask

    task automatic hit(input logic [TW-1:0] tid, input logic [DW-1:0] d, input bit rr);
        step(0, '0, 1, tid, d, 0, '0, '0, rr);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        alloc_valid_i = 0; alloc_id_i = '0; rob_wren_i = 0; rob_data_i = '0;
        refill_valid_i = 0; refill_tid_i = '0; refill_data_i = '0; rready_i = 0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        q.delete(); beats.delete();
        exp_err = 1'b0; next_tid = '0;
    endtask

    task automatic drain(input string tag);
        int budget = 60;
        while (q.size() != 0 && budget > 0) begin
            idle(1, 1);
            budget--;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] hold_id;
        logic [DW-1:0] hold_data;
        int            budget;
        int            unf[$];
        int            hi, fi;
        logic [IW-1:0] exp_ids [4];

        do_reset(3);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_afull", rob_afull_o, 0);
        chk("rst_ready", alloc_ready_o, 1);
        chk("rst_tid", alloc_tid_o, 0);
        chk("rst_rid", rid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rresp", rresp_o, 0);
        chk("rst_rlast", rlast_o, 0);

        // Reverse-order hits come back in allocation order.
        exp_ids = '{4'd3, 4'd5, 4'd7, 4'd9};
        for (int i = 0; i < 4; i++) alloc(exp_ids[i], 1);
        for (int i = 3; i >= 0; i--) hit(TW'(i), DW'(32'hA000 + i), 1);
        drain("order_drain");
        chk("order_count", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++)
            chk("order_rid", beats[i].id, exp_ids[i]);

        // Full, then one retire frees the wrapped TID 0.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) alloc(IW'(i), 0);
        chk("full_ready", alloc_ready_o, 0);
        hit('0, 32'hF00D, 0);
        budget = 5;
        while (!alloc_ready_o && budget > 0) begin idle(1, 0); budget--; end
        chk("wrap_ready", alloc_ready_o, 1);
        chk("wrap_tid", alloc_tid_o, 0);
        alloc(4'hA, 0);
        for (int i = 1; i < DEPTH; i++) hit(TW'(i), DW'(32'hB000 + i), 0);
        idle(3, 0);
        chk("afull_set", rob_afull_o, 1);
        hit('0, 32'hC0DE, 1);
        drain("wrap_drain");
        idle(3, 1);
        chk("afull_clr", rob_afull_o, 0);

        // Hit and refill together: distinct TIDs, then the same TID.
        do_reset(2);
        for (int i = 0; i < 3; i++) alloc(IW'(i + 1), 1);
        step(0, '0, 1, 3'd1, 32'h1111_0001, 1, 3'd2, 32'h2222_0002, 1);
        hit('0, 32'h0000_0A0A, 1);
        drain("dual_drain");
        chk("dual_err", err_o, 0);
        alloc(4'h6, 1);
        step(0, '0, 1, 3'd3, 32'h1111_1111, 1, 3'd3, 32'h2222_2222, 1);
        drain("same_drain");
        chk("same_data", beats[beats.size()-1].data, 32'h2222_2222);
        chk("same_err", err_o, 1);

        // Unallocated and double writes are dropped and flagged.
        do_reset(2);
        hit(3'd5, 32'hDEAD, 1);
        idle(3, 1);
        chk("unalloc_err", err_o, 1);
        chk("unalloc_rvalid", rvalid_o, 0);
        do_reset(2);
        alloc(4'h2, 0);
        alloc(4'h3, 0);
        hit(3'd1, 32'h1, 0);
        hit(3'd1, 32'h2, 0);
        chk("double_err", err_o, 1);
        hit(3'd0, 32'h3, 1);
        drain("double_drain");

        // Back-pressure: payload holds, then three back-to-back beats.
        do_reset(2);
        for (int i = 0; i < 3; i++) alloc(IW'(i + 4), 0);
        for (int i = 0; i < 3; i++) hit(TW'(i), DW'(32'h5500 + i), 0);
        budget = 5;
        while (!rvalid_o && budget > 0) begin idle(1, 0); budget--; end
        chk("bp_rvalid", rvalid_o, 1);
        hold_id = rid_o; hold_data = rdata_o;
        for (int i = 0; i < 5; i++) begin
            idle(1, 0);
            chk("bp_rid_hold", rid_o, hold_id);
            chk("bp_rdata_hold", rdata_o, hold_data);
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_stream", rvalid_o, 1);
            idle(1, 1);
        end
        chk("bp_empty", q.size(), 0);

        // Head-write latency into an empty output slot.
        do_reset(2);
        alloc(4'h1, 0);
        idle(2, 0);
        hit('0, 32'h7777, 0);
        chk("lat_n1", rvalid_o, 64'(BYP));
        idle(1, 0);
        chk("lat_n2", rvalid_o, 1);
        chk("lat_data", rdata_o, 32'h7777);
        idle(1, 1);

        // Reset mid-operation discards everything.
        do_reset(2);
        for (int i = 0; i < 3; i++) alloc(IW'(i), 0);
        hit(3'd1, 32'h11, 0);
        hit(3'd2, 32'h22, 0);
        do_reset(1);
        chk("mid_rvalid", rvalid_o, 0);
        chk("mid_ready", alloc_ready_o, 1);
        chk("mid_tid", alloc_tid_o, 0);
        chk("mid_err", err_o, 0);
        alloc(4'h9, 1);
        hit('0, 32'h99, 1);
        drain("mid_drain");

        // Randomized legal traffic.
        do_reset(2);
        for (int c = 0; c < 2500; c++) begin
            unf.delete();
            for (int i = 0; i < q.size(); i++) if (!q[i].filled) unf.push_back(i);
            hi = -1; fi = -1;
            if (unf.size() > 0 && $urandom_range(2, 0) != 0) hi = unf[$urandom_range(unf.size()-1, 0)];
            if (unf.size() > 1 && $urandom_range(2, 0) == 0) begin
                fi = unf[$urandom_range(unf.size()-1, 0)];
                if (fi == hi) fi = -1;
            end
            step($urandom_range(1, 0) == 1, IW'($urandom),
                 hi >= 0, (hi >= 0) ? q[hi].tid : '0, DW'($urandom),
                 fi >= 0, (fi >= 0) ? q[fi].tid : '0, DW'($urandom),
                 $urandom_range(3, 0) != 0);
        end
        budget = 100;
        while (q.size() != 0 && budget > 0) begin
            hi = -1;
            for (int i = 0; i < q.size(); i++) if (!q[i].filled && hi < 0) hi = i;
            if (hi >= 0) hit(q[hi].tid, DW'($urandom), 1);
            else idle(1, 1);
            budget--;
        end
        chk("rand_drain", q.size(), 0);
        chk("rand_err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
